// File: rtl/polvecp2bs_pack.sv
// polvecp2bs_pack: packs a Saber polynomial vector (four 16-bit lanes per
// 64-bit RAM word, EP significant bits per lane) into a dense little-endian
// EP-bit bitstream in the same RAM. One input word per cycle, no stalls.
module polvecp2bs_pack #(
  parameter int N  = 256,
  parameter int L  = 3,
  parameter int EP = 10,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          busy,
  output logic          done
);

  localparam int NIN = N * L / 4;      // input words per run
  localparam int PW  = 4 * EP;         // packed bits contributed per input word
  localparam int BW  = 64 + PW;        // accumulator width, enough for fill<64 plus one word
  localparam int CW  = $clog2(NIN);    // read counter width
  localparam int WW  = $clog2(NIN);    // write counter width (output words < input words)

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t        state_q;
  logic          rd_en_q, rvld_q, wr_en_q, busy_q, done_q;
  logic [AW-1:0] rd_addr_q, wr_addr_q, dst_q;
  logic [63:0]   wr_data_q;
  logic [CW-1:0] rd_cnt_q;
  logic [WW-1:0] wcnt_q;
  logic [BW-1:0] acc_q;
  logic [6:0]    fill_q;

  logic [PW-1:0] pk;
  logic [BW-1:0] acc_n;
  logic [7:0]    sum;
  logic          emit;

  // Compact the four masked lanes of the incoming word into PW contiguous bits
  // and merge them into the accumulator above the current fill level.
  always_comb begin
    pk = '0;
    for (int b = 0; b < 64; b++) begin
      if ((b % 16) < EP) pk[(b / 16) * EP + (b % 16)] = rd_data[b];
    end
    acc_n = acc_q | ({{(BW-PW){1'b0}}, pk} << fill_q);
    sum   = {1'b0, fill_q} + 8'(PW);
    emit  = (sum >= 8'd64);
  end

  // Control FSM, read address generation, accumulator and registered writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rvld_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      dst_q     <= '0;
      wr_data_q <= '0;
      rd_cnt_q  <= '0;
      wcnt_q    <= '0;
      acc_q     <= '0;
      fill_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      rvld_q  <= rd_en_q;

      // RAM returns data one cycle after the request
      if (rvld_q) begin
        if (emit) begin
          wr_en_q   <= 1'b1;
          wr_data_q <= acc_n[63:0];
          wr_addr_q <= dst_q + AW'(wcnt_q);
          wcnt_q    <= wcnt_q + WW'(1);
          acc_q     <= acc_n >> 64;
          fill_q    <= 7'(sum - 8'd64);
        end else begin
          acc_q     <= acc_n;
          fill_q    <= sum[6:0];
        end
      end

      case (state_q)
        IDLE: if (start) begin
          state_q   <= READ;
          busy_q    <= 1'b1;
          rd_en_q   <= 1'b1;
          rd_addr_q <= src_base;
          dst_q     <= dst_base;
          rd_cnt_q  <= '0;
          wcnt_q    <= '0;
          acc_q     <= '0;
          fill_q    <= '0;
        end
        READ: if (rd_cnt_q == CW'(NIN - 1)) begin
          rd_en_q <= 1'b0;
          state_q <= DRAIN;
        end else begin
          rd_addr_q <= rd_addr_q + AW'(1);
          rd_cnt_q  <= rd_cnt_q + CW'(1);
        end
        // The last data word's write is already issued once rvld drops
        DRAIN: if (!rvld_q) begin
          state_q <= FIN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        FIN: if (!start) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_polvecp2bs_pack.sv
// Directed bench for polvecp2bs_pack with a 1-cycle-latency RAM model.
module tb_polvecp2bs_pack;

  localparam int SRC = 16;
  localparam int DST = 512;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  src_base, dst_base, rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data;
  logic        rd_en, wr_en, busy, done;

  polvecp2bs_pack dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:1023];
  logic [63:0] exp_w [0:119];
  logic [9:0]  coef [0:767];

  int cyc = 0, s_cyc = 0, rd_n = 0, first_rd = 0, last_rd = 0;
  int wr_n = 0, first_wr = 0, last_wr = 0, done_cyc = 0, wr_total = 0;
  logic done_p = 1'b0;
  int n_chk = 0, n_fail = 0;

  // RAM model plus per-run trace; samples pre-edge values, cycle k ends at edge k
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rd_en) begin
      rd_data <= mem[rd_addr];
      rd_n = rd_n + 1;
      if (rd_n == 1) first_rd = cyc;
      last_rd = cyc;
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_n = wr_n + 1;
      wr_total = wr_total + 1;
      if (wr_n == 1) first_wr = cyc;
      last_wr = cyc;
    end
    if (done && !done_p) done_cyc = cyc;
    done_p = done;
    if (!rst && start && !busy && !done) begin
      s_cyc = cyc; rd_n = 0; wr_n = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clr_src();
    for (int i = 0; i < 192; i++) mem[SRC + i] = '0;
  endtask

  task automatic clr_dst();
    for (int i = 0; i < 128; i++) mem[DST + i] = JUNK;
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 120; i++) exp_w[i] = '0;
  endtask

  // One full start/done handshake with timing checks relative to acceptance
  task automatic run_once(input string tag);
    int k;
    @(negedge clk); start = 1'b1;
    k = 0;
    while (!done && k < 400) begin @(negedge clk); k++; end
    chk({tag, " done_reached"}, {63'd0, done}, 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, " done_held"},  {63'd0, done}, 64'd1);
    chk({tag, " busy_low"},   {63'd0, busy}, 64'd0);
    chk({tag, " first_rd"},   64'(first_rd - s_cyc), 64'd1);
    chk({tag, " last_rd"},    64'(last_rd - s_cyc),  64'd192);
    chk({tag, " rd_count"},   64'(rd_n), 64'd192);
    chk({tag, " first_wr"},   64'(first_wr - s_cyc), 64'd4);
    chk({tag, " last_wr"},    64'(last_wr - s_cyc),  64'd194);
    chk({tag, " wr_count"},   64'(wr_n), 64'd120);
    chk({tag, " done_cyc"},   64'(done_cyc - s_cyc), 64'd195);
    start = 1'b0;
    @(negedge clk);
    chk({tag, " done_drop"},  {63'd0, done}, 64'd0);
  endtask

  task automatic chk_out(input string tag);
    int nbad;
    nbad = 0;
    for (int m = 0; m < 120; m++) if (mem[DST + m] !== exp_w[m]) nbad++;
    chk({tag, " first_word"}, mem[DST], exp_w[0]);
    chk({tag, " bad_words"}, 64'(nbad), 64'd0);
    chk({tag, " past_end"}, mem[DST + 120], JUNK);
  endtask

  initial begin
    int nbad, wt, k;
    logic [63:0] w;
    logic [9:0]  c;
    int bit_i;

    rst = 1'b1; start = 1'b0;
    src_base = 10'(SRC); dst_base = 10'(DST);
    rd_data = '0;
    clr_src(); clr_dst();
    repeat (3) @(negedge clk);
    chk("reset rd_en",   {63'd0, rd_en}, 64'd0);
    chk("reset wr_en",   {63'd0, wr_en}, 64'd0);
    chk("reset busy",    {63'd0, busy},  64'd0);
    chk("reset done",    {63'd0, done},  64'd0);
    chk("reset rd_addr", {54'd0, rd_addr}, 64'd0);
    chk("reset wr_addr", {54'd0, wr_addr}, 64'd0);
    chk("reset wr_data", wr_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic packing of four small coefficients
    clr_src(); clr_dst(); clr_exp();
    mem[SRC] = 64'h0004_0003_0002_0001;
    exp_w[0] = 64'h0000_0001_0030_0801;
    run_once("basic");
    chk_out("basic");

    // Coefficient 6 straddles output words 0 and 1
    clr_src(); clr_dst(); clr_exp();
    mem[SRC + 1] = 64'h0000_03FF_0000_0000;
    exp_w[0] = 64'hF000_0000_0000_0000;
    exp_w[1] = 64'h0000_0000_0000_003F;
    run_once("straddle");
    chk_out("straddle");
    chk("straddle word1", mem[DST + 1], 64'h0000_0000_0000_003F);

    // All-ones input: upper lane bits must be masked away
    clr_dst();
    for (int i = 0; i < 192; i++) mem[SRC + i] = '1;
    for (int i = 0; i < 120; i++) exp_w[i] = '1;
    run_once("saturate");
    chk_out("saturate");

    // Random coefficients with junk in the ignored lane bits; software pack
    clr_dst(); clr_exp();
    for (int j = 0; j < 768; j++) begin
      coef[j] = 10'($urandom_range(0, 1023));
      w = mem[SRC + j / 4];
      w[16 * (j % 4) +: 16] = {6'($urandom_range(0, 63)), coef[j]};
      mem[SRC + j / 4] = w;
      for (int b = 0; b < 10; b++) begin
        bit_i = 10 * j + b;
        w = exp_w[bit_i / 64];
        w[bit_i % 64] = coef[j][b];
        exp_w[bit_i / 64] = w;
      end
    end
    run_once("random");
    chk_out("random");
    // Unpack the written stream and recover the original coefficients
    nbad = 0;
    for (int j = 0; j < 768; j++) begin
      for (int b = 0; b < 10; b++) begin
        bit_i = 10 * j + b;
        w = mem[DST + bit_i / 64];
        c[b] = w[bit_i % 64];
      end
      if (c !== coef[j]) nbad++;
    end
    chk("roundtrip bad_coefs", 64'(nbad), 64'd0);

    // Second start on the same data must give an identical run
    clr_dst();
    run_once("rerun");
    chk_out("rerun");

    // Reset asserted at S+50 aborts the run
    clr_dst();
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    k = 0;
    while (cyc < s_cyc + 49 && k < 100) begin @(negedge clk); k++; end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort rd_en", {63'd0, rd_en}, 64'd0);
    chk("abort wr_en", {63'd0, wr_en}, 64'd0);
    chk("abort busy",  {63'd0, busy},  64'd0);
    chk("abort done",  {63'd0, done},  64'd0);
    wt = wr_total;
    repeat (30) @(negedge clk);
    chk("abort no_writes", 64'(wr_total - wt), 64'd0);
    clr_dst();
    run_once("after_rst");
    chk_out("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/polvecp2bs_pack.md
Name: polvecp2bs_pack

Overview:
- Encryption-side packer: converts a Saber polynomial vector of EP-bit coefficients into the contiguous little-endian bitstream stored in the ciphertext area (the inverse of the bs2polvecp unpack step).
- Source layout: four coefficients per 64-bit RAM word, in 16-bit lanes.
- Destination layout: dense EP-bit bitstream.
- Sits beside the other ComputeCore3 helpers on the shared data RAM; started and acknowledged through the command/done handshake.

Parameters:
- N, 256, coefficients per polynomial
- L, 3, polynomials per vector
- EP, 10, bits kept per coefficient
- AW, 10, RAM address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  command strobe; level held high by controller until done seen
- src_base  in  AW  first RAM word of coefficient vector
- dst_base  in  AW  first RAM word of output bitstream
- rd_en  out  1  RAM read request
- rd_addr  out  AW  RAM read address
- rd_data  in  64  RAM read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM write address
- wr_data  out  64  RAM write data
- busy  out  1  high from start acceptance until done
- done  out  1  completion flag

Behaviour:
- Reset values: rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, busy=0, done=0, accumulator and fill counter=0, FSM=IDLE.
- Sizes:
  - NIN = N*L/4 = 192 input words.
  - NOUT = N*L*EP/64 = 120 output words.
  - N*EP is a multiple of 64, so there is no partial final word.
- Coefficient j sits in input word src_base+j/4, lane j%4; lane k occupies bits [16k+EP-1:16k]. Lane bits [16k+15:16k+EP] are ignored (masked).
- Coefficient j occupies bitstream bits [EP*j+EP-1 : EP*j]. Output word m holds bitstream bits [64m+63:64m] and is written to dst_base+m.
- FSM states:
  - IDLE: start=1 sampled at cycle S moves to READ; src_base/dst_base are latched; busy=1 from S+1.
  - READ: rd_en=1 for NIN consecutive cycles, S+1..S+NIN, with rd_addr=src_base+i.
  - DRAIN: waits for the last read data and the last write.
  - DONE: done=1, busy=0. Stay while start=1; start=0 returns to IDLE, done=0 the following cycle.
- Accumulator: 104-bit shift buffer plus 7-bit fill count.
  - Each valid rd_data appends 4*EP=40 bits at position fill.
  - If fill+40 >= 64, the low 64 bits are emitted and the buffer shifts down 64.
  - fill never exceeds 103; one input word per cycle with no stall.
- Write outputs are registered: an emission decided in the data-arrival cycle t appears as wr_en=1 in t+1, with wr_addr=dst_base+m and m incrementing per write.
- Timing, per start:
  - First data at S+2.
  - First write at S+4.
  - Last data at S+NIN+1.
  - Last write at S+NIN+2.
  - done=1 at S+NIN+3.
  - Exactly NOUT writes, no more.
- Pattern: every 8 input words produce exactly 5 output words; fill returns to 0 after each 8-word group.
- Address arithmetic wraps modulo 2^AW; no range check.
- start while busy or in DONE is ignored; no restart until start has been seen low in DONE.
- rst mid-operation: everything returns to reset values next cycle, no further rd_en/wr_en, partial output is left in RAM as written.
- rst and start in the same cycle: rst wins.

Test Plan:
- Basic packing: input word0=0x0004_0003_0002_0001, all other words 0 -> first write wr_addr=dst_base, wr_data=0x0000_0001_0030_0801; the remaining 119 writes are 0.
- Straddle: coefficient 6 (word1 lane2)=0x3FF, all others 0 -> out word0=0xF000_0000_0000_0000, out word1=0x0000_0000_0000_003F.
- Saturation and masking: all 192 input words = 0xFFFF_FFFF_FFFF_FFFF -> 120 writes of 0xFFFF_FFFF_FFFF_FFFF, identical to all lanes = 0x03FF.
- Round trip: random coefficients < 2^EP -> output matches a software pack; feeding the output to the bs2polvecp unpacker returns the original coefficients.
- Timing and handshake, with src_base=16, dst_base=512:
  - start held from S -> rd_en S+1..S+192; wr_en exactly 120 cycles, first at S+4, last at S+194.
  - done rises at S+195 and stays high while start=1; clearing start drops done 1 cycle later.
  - A second start then produces an identical run.
- Reset: assert rst at S+50 for 1 cycle -> next cycle rd_en=wr_en=busy=done=0, no writes afterwards; a new start gives correct full output.
